// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg : shared CPU word, opcode, fetch-state and IF/ID types | rev 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDIU = 6'h09,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
    logic  valid;
  } ifid_t;

  localparam word_t c_pc_step = 32'd4;
  localparam ifid_t c_ifid_bubble = '0;

  // Wraps modulo 2^32 by construction.
  function automatic word_t next_pc(input word_t pc);
    return pc + c_pc_step;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// fetch_unit_if : signal bundle between fetch, hazard unit and imem | rev 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  freeze;
  logic  flush;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  logic  ihit;
  word_t iload;
  logic  imemREN;
  word_t imemaddr;
  word_t ifid_instr;
  word_t ifid_pc;
  word_t ifid_npc;
  logic  ifid_valid;
  logic  halted;

  modport fu (
    input  freeze, flush, redirect, redirect_pc, halt, ihit, iload,
    output imemREN, imemaddr, ifid_instr, ifid_pc, ifid_npc, ifid_valid, halted
  );

endinterface

`default_nettype wire

// File: rtl/ifid_reg.sv
// ============================================================================
// ifid_reg : IF/ID pipeline register, flush beats enable, bubble = 0 | rev 1.0
// ============================================================================
`default_nettype none

module ifid_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  i_en,
  input  logic  i_flush,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_q <= c_ifid_bubble;
    end else if (i_flush) begin
      r_q <= c_ifid_bubble;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC, redirect-drain/halt FSM and IF/ID register | rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h00000000
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  freeze,
  input  logic  flush,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  input  logic  ihit,
  input  word_t iload,
  output logic  imemREN,
  output word_t imemaddr,
  output word_t ifid_instr,
  output word_t ifid_pc,
  output word_t ifid_npc,
  output logic  ifid_valid,
  output logic  halted
);

  fetch_state_t r_state, w_state_nxt;
  word_t        r_pc, w_pc_nxt;
  word_t        r_tgt, w_tgt_nxt;
  logic         w_go_halt;
  logic         w_ifid_load;
  logic         w_ifid_bubble;
  ifid_t        w_ifid_d;
  ifid_t        w_ifid_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= FETCH;
      r_pc    <= PC_INIT;
      r_tgt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_tgt_nxt     = r_tgt;
    w_go_halt     = halt & ~flush & ~redirect;
    w_ifid_load   = 1'b0;
    w_ifid_bubble = 1'b1;
    w_ifid_d      = '{instr: iload, pc: r_pc, npc: next_pc(r_pc), valid: 1'b1};

    unique case (r_state)
      FETCH: begin
        w_ifid_load   = ihit & ~redirect & ~w_go_halt & ~freeze & ~flush;
        w_ifid_bubble = flush | (~freeze & ~w_ifid_load);
        if (w_go_halt) begin
          w_state_nxt = HALT;
        end else if (redirect) begin
          if (ihit) begin
            w_pc_nxt = redirect_pc;
          end else begin
            w_tgt_nxt   = redirect_pc;
            w_state_nxt = DRAIN;
          end
        end else if (ihit & ~freeze & ~flush) begin
          w_pc_nxt = next_pc(r_pc);
        end
      end

      // The old request must complete before the new target can be issued.
      DRAIN: begin
        w_ifid_bubble = flush | ~freeze;
        if (w_go_halt) begin
          w_state_nxt = HALT;
        end else if (redirect) begin
          if (ihit) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = FETCH;
          end else begin
            w_tgt_nxt = redirect_pc;
          end
        end else if (ihit) begin
          w_pc_nxt    = r_tgt;
          w_state_nxt = FETCH;
        end
      end

      HALT: begin
        w_ifid_bubble = 1'b1;
      end

      default: begin
        w_state_nxt   = FETCH;
        w_ifid_bubble = 1'b1;
      end
    endcase
  end

  ifid_reg u_ifid_reg (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_en    (w_ifid_load),
    .i_flush (w_ifid_bubble),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign imemREN    = (r_state != HALT);
  assign imemaddr   = {r_pc[31:2], 2'b00};
  assign halted     = (r_state == HALT);
  assign ifid_instr = w_ifid_q.instr;
  assign ifid_pc    = w_ifid_q.pc;
  assign ifid_npc   = w_ifid_q.npc;
  assign ifid_valid = w_ifid_q.valid;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h00000000, PC loaded on reset.
REQ-002 Port CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 Port nRST  input  1  reset; asynchronous, active-low.
REQ-004 Port freeze  input  1  load-use stall from the hazard unit; hold PC and IF/ID.
REQ-005 Port flush  input  1  control-transfer squash from the hazard unit; bubble IF/ID.
REQ-006 Port redirect  input  1  taken branch or jump; fetch resumes at redirect_pc.
REQ-007 Port redirect_pc  input  32  branch or jump target (word_t).
REQ-008 Port halt  input  1  HALT opcode decoded in ID.
REQ-009 Port ihit  input  1  instruction access completes this cycle.
REQ-010 Port iload  input  32  instruction word, valid when ihit=1.
REQ-011 Port imemREN  output  1  instruction read request.
REQ-012 Port imemaddr  output  32  instruction address, always word-aligned.
REQ-013 Port ifid_instr  output  32  IF/ID instruction, read by the hazard unit and decode.
REQ-014 Port ifid_pc  output  32  PC of ifid_instr.
REQ-015 Port ifid_npc  output  32  ifid_pc + 4.
REQ-016 Port ifid_valid  output  1  IF/ID holds a real instruction.
REQ-017 Port halted  output  1  fetch permanently stopped.

Function
REQ-018 The FSM SHALL have three states: FETCH, DRAIN and HALT.
REQ-019 In FETCH and DRAIN, imemREN SHALL be 1; in HALT, imemREN SHALL be 0.
REQ-020 imemaddr SHALL be {pc[31:2],2'b00} and SHALL stay stable while a request is outstanding (imemREN=1, ihit=0).
REQ-021 In FETCH, when ihit=1, freeze=0, flush=0 and redirect=0, the block SHALL register IF/ID as {iload, pc, pc+4, valid=1} and set pc to pc+4.
REQ-022 In FETCH, when ihit=0 and freeze=0, the block SHALL load IF/ID with a bubble (all fields 0) and hold pc.
REQ-023 When freeze=1 and flush=0, IF/ID and pc SHALL hold, and a concurrent ihit SHALL be discarded (the address is re-fetched).
REQ-024 When flush=1, IF/ID SHALL load a bubble regardless of freeze or ihit; flush takes priority.
REQ-025 In FETCH, when redirect=1 and ihit=1, pc SHALL load redirect_pc, iload SHALL be discarded, and the state SHALL remain FETCH.
REQ-026 In FETCH, when redirect=1 and ihit=0, the block SHALL latch redirect_pc into tgt and go to DRAIN, with pc held.
REQ-027 In DRAIN, the block SHALL keep requesting the old pc; on ihit it SHALL discard iload, set pc to tgt, and return to FETCH.
REQ-028 In DRAIN, each new redirect SHALL overwrite tgt, so the newest target wins.
REQ-029 In DRAIN, IF/ID SHALL receive a bubble every cycle unless freeze=1.
REQ-030 When halt=1 and flush=0 and redirect=0 in FETCH or DRAIN, the block SHALL go to HALT on the next edge and abandon any outstanding request.
REQ-031 In HALT, IF/ID SHALL load a bubble, halted SHALL be 1, and the block SHALL stay there until reset.
REQ-032 Next-PC arithmetic SHALL be 32-bit modulo: 32'hFFFFFFFC + 4 = 32'h00000000, with no flag raised.

Reset
REQ-033 On nRST=0, the block SHALL immediately set pc=PC_INIT, tgt=0, state=FETCH, all IF/ID fields to 0, and halted=0.
REQ-034 After reset, imemREN=1 and imemaddr=PC_INIT in the first cycle.
REQ-035 A reset during DRAIN or HALT SHALL discard tgt and any outstanding access.

Structure
REQ-036 word_t and the opcode enum SHALL come from cpu_types_pkg.
REQ-037 fetch_state_t (FETCH, DRAIN, HALT) SHALL be added to cpu_types_pkg.
REQ-038 Ports SHALL be grouped in interface fetch_unit_if.vh.
REQ-039 The IF/ID register SHALL be sub-module ifid_reg, with enable, flush and a bubble value of 0.

Verification
REQ-040 Reset with PC_INIT=0 and ihit tied to 1 -> imemaddr steps 0, 4, 8; ifid_pc lags one cycle; ifid_valid=1 from cycle 2.
REQ-041 freeze=1 for 2 cycles at pc=8 -> ifid_instr unchanged, imemaddr stays 8, fetch resumes at 8 afterwards.
REQ-042 redirect=1 to 32'h40 with ihit=0 for 3 cycles -> DRAIN, addr held, then one bubble, then imemaddr=32'h40.
REQ-043 In DRAIN, redirect to 32'h40 then 32'h80 -> next fetch address is 32'h80.
REQ-044 flush=1 and freeze=1 in the same cycle -> IF/ID becomes a bubble; halt=1 with flush=1 is ignored.
REQ-045 halt=1 alone -> next cycle imemREN=0 and halted=1; nRST pulse mid-HALT -> imemaddr=PC_INIT and halted=0.
